// File: rtl/top_alu_pkg.sv
// Shared opcode encodings and default widths for the switch/button ALU wrapper.
package top_alu_pkg;

    localparam int DEF_NB_OPERANDO = 8;
    localparam int DEF_NB_OPCODE   = 6;

    localparam logic [5:0] ADD = 6'b100000;
    localparam logic [5:0] SUB = 6'b100010;
    localparam logic [5:0] AND = 6'b100100;
    localparam logic [5:0] OR  = 6'b100101;
    localparam logic [5:0] XOR = 6'b100110;
    localparam logic [5:0] NOR = 6'b100111;
    localparam logic [5:0] SRA = 6'b000011;
    localparam logic [5:0] SRL = 6'b000010;

endpackage

// File: rtl/top_alu_alu.sv
// Combinational 8-op ALU; unknown opcodes give zero, all results wrap.
module alu
    import top_alu_pkg::*;
#(
    parameter int NB_OPERANDO = DEF_NB_OPERANDO,
    parameter int NB_OPCODE   = DEF_NB_OPCODE,
    parameter int NB_OUT      = DEF_NB_OPERANDO
) (
    input  logic [NB_OPERANDO-1:0] i_a,
    input  logic [NB_OPERANDO-1:0] i_b,
    input  logic [NB_OPCODE-1:0]   i_op,
    output logic [NB_OUT-1:0]      o_result
);

    logic [NB_OPERANDO-1:0] result;

    always_comb begin
        result = '0;
        case (i_op)
            NB_OPCODE'(ADD): result = i_a + i_b;
            NB_OPCODE'(SUB): result = i_a - i_b;
            NB_OPCODE'(AND): result = i_a & i_b;
            NB_OPCODE'(OR):  result = i_a | i_b;
            NB_OPCODE'(XOR): result = i_a ^ i_b;
            NB_OPCODE'(NOR): result = ~(i_a | i_b);
            // Full-width shift amount: oversize shifts saturate to 0 / sign fill.
            NB_OPCODE'(SRA): result = $signed(i_a) >>> i_b;
            NB_OPCODE'(SRL): result = i_a >> i_b;
            default:         result = '0;
        endcase
    end

    assign o_result = NB_OUT'(result);

endmodule

// File: rtl/top_alu.sv
// Board wrapper: buttons load A/B/opcode from the switch bus and commit the ALU result.
// Optional macro TOP_ALU_SYNC_EN adds two-flop synchronizers on buttons and switches.
module top_alu
    import top_alu_pkg::*;
#(
    parameter int NB_OPERANDO = DEF_NB_OPERANDO,
    parameter int NB_OPCODE   = DEF_NB_OPCODE,
    parameter int NB_OUT      = DEF_NB_OPERANDO
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [NB_OPERANDO-1:0] i_switch,
    input  logic                   i_boton_1,
    input  logic                   i_boton_2,
    input  logic                   i_boton_3,
    input  logic                   i_boton_4,
    output logic [NB_OUT-1:0]      out
);

    logic [3:0]             btn_raw;
    logic [3:0]             btn_in;
    logic [NB_OPERANDO-1:0] sw_in;
    logic [3:0]             btn_q;
    logic [3:0]             rise_reg;
    logic [NB_OPERANDO-1:0] a_reg;
    logic [NB_OPERANDO-1:0] b_reg;
    logic [NB_OPCODE-1:0]   op_reg;
    logic [NB_OUT-1:0]      out_reg;
    logic [NB_OUT-1:0]      alu_result;

    assign btn_raw = {i_boton_4, i_boton_3, i_boton_2, i_boton_1};

`ifdef TOP_ALU_SYNC_EN
    logic [3:0]             btn_s1_reg;
    logic [3:0]             btn_s2_reg;
    logic [NB_OPERANDO-1:0] sw_s1_reg;
    logic [NB_OPERANDO-1:0] sw_s2_reg;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            btn_s1_reg <= '0;
            btn_s2_reg <= '0;
            sw_s1_reg  <= '0;
            sw_s2_reg  <= '0;
        end else begin
            btn_s1_reg <= btn_raw;
            btn_s2_reg <= btn_s1_reg;
            sw_s1_reg  <= i_switch;
            sw_s2_reg  <= sw_s1_reg;
        end
    end

    assign btn_in = btn_s2_reg;
    assign sw_in  = sw_s2_reg;
`else
    assign btn_in = btn_raw;
    assign sw_in  = i_switch;
`endif

    // Registered rise pulse: a press seen at edge N acts on the registers at edge N+1.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            btn_q    <= '0;
            rise_reg <= '0;
        end else begin
            btn_q    <= btn_in;
            rise_reg <= btn_in & ~btn_q;
        end
    end

    alu #(
        .NB_OPERANDO(NB_OPERANDO),
        .NB_OPCODE  (NB_OPCODE),
        .NB_OUT     (NB_OUT)
    ) u_alu (
        .i_a     (a_reg),
        .i_b     (b_reg),
        .i_op    (op_reg),
        .o_result(alu_result)
    );

    // out samples the ALU before any same-edge operand/opcode update lands.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            a_reg   <= '0;
            b_reg   <= '0;
            op_reg  <= '0;
            out_reg <= '0;
        end else begin
            if (rise_reg[0]) a_reg   <= sw_in;
            if (rise_reg[1]) b_reg   <= sw_in;
            if (rise_reg[2]) op_reg  <= sw_in[NB_OPCODE-1:0];
            if (rise_reg[3]) out_reg <= alu_result;
        end
    end

    assign out = out_reg;

endmodule

// File: tb/tb_top_alu.sv
// Directed self-checking bench for top_alu: reset, arithmetic, shifts, logic and button corner cases.
module tb_top_alu;

`ifdef TOP_ALU_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] sw = 8'h00;
    logic [3:0] btns = 4'b0000;
    logic [7:0] out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    top_alu dut (
        .i_clk    (clk),
        .i_reset  (rst_n),
        .i_switch (sw),
        .i_boton_1(btns[0]),
        .i_boton_2(btns[1]),
        .i_boton_3(btns[2]),
        .i_boton_4(btns[3]),
        .out      (out)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Press button idx (0..3) for 3 cycles with the switch held, then let the load settle.
    task automatic press(input int idx, input logic [7:0] val);
        sw = val;
        btns[idx] = 1'b1;
        tick(3);
        btns[idx] = 1'b0;
        tick(LAT + 1);
        $display("press b%0d sw=%h -> out=%h", idx + 1, val, out);
    endtask

    task automatic test_reset;
        for (int i = 0; i < 5; i++) begin
            sw   = 8'($urandom);
            btns = 4'($urandom);
            tick(1);
        end
        n_checks++;
        if (out !== 8'h00) begin n_fail++; $display("FAIL reset_out: got %h expected 00", out); end
        n_checks++;
        if (dut.a_reg !== 8'h00 || dut.b_reg !== 8'h00 || dut.op_reg !== 6'h00) begin
            n_fail++;
            $display("FAIL reset_regs: got a=%h b=%h op=%h expected 00 00 00", dut.a_reg, dut.b_reg, dut.op_reg);
        end
        btns = 4'b0000;
        tick(1);
        rst_n = 1'b1;
        tick(5);
        n_checks++;
        if (out !== 8'h00) begin n_fail++; $display("FAIL reset_release_out: got %h expected 00", out); end
        $display("reset done out=%h", out);
    endtask

    task automatic test_add;
        press(0, 8'hC0);
        press(1, 8'h01);
        press(2, 8'h20);
        sw = 8'h5A;
        btns[3] = 1'b1;
        tick(LAT);
        n_checks++;
        if (out !== 8'h00) begin n_fail++; $display("FAIL add_latency_old: got %h expected 00", out); end
        tick(1);
        n_checks++;
        if (out !== 8'hC1) begin n_fail++; $display("FAIL add_result: got %h expected c1", out); end
        tick(3 - LAT);
        btns[3] = 1'b0;
        tick(LAT + 1);
        $display("add commit out=%h", out);
    endtask

    task automatic test_sub;
        press(2, 8'h22);
        n_checks++;
        if (out !== 8'hC1) begin n_fail++; $display("FAIL sub_hold_before_commit: got %h expected c1", out); end
        press(3, 8'h00);
        n_checks++;
        if (out !== 8'hBF) begin n_fail++; $display("FAIL sub_result: got %h expected bf", out); end
    endtask

    task automatic test_shifts;
        logic [7:0] b_tab   [4] = '{8'h01, 8'h01, 8'h09, 8'h09};
        logic [7:0] op_tab  [4] = '{8'h03, 8'h02, 8'h02, 8'h03};
        logic [7:0] exp_tab [4] = '{8'hE0, 8'h60, 8'h00, 8'hFF};
        press(0, 8'hC0);
        for (int i = 0; i < 4; i++) begin
            press(1, b_tab[i]);
            press(2, op_tab[i]);
            press(3, 8'h00);
            n_checks++;
            if (out !== exp_tab[i]) begin
                n_fail++;
                $display("FAIL shift_%0d op=%h b=%h: got %h expected %h", i, op_tab[i], b_tab[i], out, exp_tab[i]);
            end
        end
    endtask

    task automatic test_logic;
        logic [7:0] op_tab  [5] = '{8'h24, 8'h25, 8'h26, 8'h27, 8'h3F};
        logic [7:0] exp_tab [5] = '{8'h00, 8'hCF, 8'hCF, 8'h30, 8'h00};
        press(1, 8'h0F);
        for (int i = 0; i < 5; i++) begin
            press(2, op_tab[i]);
            press(3, 8'h00);
            n_checks++;
            if (out !== exp_tab[i]) begin
                n_fail++;
                $display("FAIL logic_%0d op=%h: got %h expected %h", i, op_tab[i], out, exp_tab[i]);
            end
        end
    endtask

    task automatic test_held;
        press(1, 8'h09);
        sw = 8'h5A;
        btns[0] = 1'b1;
        tick(LAT + 1);
        for (int i = 0; i < 9; i++) begin
            sw = 8'h80 | 8'(i);
            tick(1);
        end
        btns[0] = 1'b0;
        tick(LAT + 1);
        n_checks++;
        if (dut.a_reg !== 8'h5A) begin n_fail++; $display("FAIL held_a: got %h expected 5a", dut.a_reg); end
        press(2, 8'h20);
        press(3, 8'h00);
        n_checks++;
        if (out !== 8'h63) begin n_fail++; $display("FAIL held_add: got %h expected 63", out); end
    endtask

    task automatic test_simultaneous;
        press(1, 8'h01);
        sw = 8'h10;
        btns = 4'b1001;
        tick(3);
        btns = 4'b0000;
        tick(LAT + 1);
        $display("simultaneous b1+b4 sw=10 -> out=%h", out);
        n_checks++;
        if (out !== 8'h5B) begin n_fail++; $display("FAIL simul_old_a: got %h expected 5b", out); end
        n_checks++;
        if (dut.a_reg !== 8'h10) begin n_fail++; $display("FAIL simul_a_load: got %h expected 10", dut.a_reg); end
        press(3, 8'h00);
        n_checks++;
        if (out !== 8'h11) begin n_fail++; $display("FAIL simul_new_a: got %h expected 11", out); end
    endtask

    task automatic test_reset_mid;
        sw = 8'h77;
        btns[0] = 1'b1;
        tick(1);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (out !== 8'h00) begin n_fail++; $display("FAIL midreset_out: got %h expected 00", out); end
        n_checks++;
        if (dut.a_reg !== 8'h00 || dut.b_reg !== 8'h00 || dut.op_reg !== 6'h00) begin
            n_fail++;
            $display("FAIL midreset_regs: got a=%h b=%h op=%h expected 00 00 00", dut.a_reg, dut.b_reg, dut.op_reg);
        end
        tick(2);
        rst_n = 1'b1;
        tick(LAT + 1);
        n_checks++;
        if (dut.a_reg !== 8'h77) begin n_fail++; $display("FAIL held_through_reset_a: got %h expected 77", dut.a_reg); end
        btns = 4'b0000;
        tick(2);
        $display("mid-press reset done a=%h out=%h", dut.a_reg, out);
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_shifts();
        test_logic();
        test_held();
        test_simultaneous();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
